// File: rtl/control_pkg.sv
// Shared decode constants for the RV32I control block: opcodes and the
// select/ALU encodings the datapath expects.
package control_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_SUB  = 2'b01,
        ALU_OP_FUNC = 2'b10
    } alu_op_t;

endpackage

// File: rtl/control_alu_decoder.sv
// ALU decoder: turns the main decoder's alu_op plus func3/func7[5] into an
// ALU operation, flagging the func combinations this core does not implement.
module control_alu_decoder
    import control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (func3)
                    // ADDI has no SUB form, so func7 only matters for R-type
                    3'b000: alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: begin
                        alu_control = ALU_SRL;
                        illegal     = func7_5;
                    end
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main decoder for the single-cycle RV32I core: combinational datapath
// selects plus a sticky illegal-instruction status flag.
module control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    output logic       reg_write,
    output logic       mem_write,
    output logic       alu_source,
    output logic [1:0] result_source,
    output logic [2:0] imm_type,
    output logic [2:0] alu_control,
    output logic       pc_src,
    output logic       illegal_instr,
    output logic       illegal_seen
);

    alu_op_t alu_op;
    logic    is_rtype;
    logic    is_branch;
    logic    is_jal;
    logic    op_illegal;
    logic    alu_illegal;
    logic    unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        alu_source    = 1'b0;
        result_source = RES_ALU;
        imm_type      = IMM_I;
        alu_op        = ALU_OP_ADD;
        is_rtype      = 1'b0;
        is_branch     = 1'b0;
        is_jal        = 1'b0;
        op_illegal    = 1'b0;
        case (op_code)
            OP_LW: begin
                reg_write     = 1'b1;
                alu_source    = 1'b1;
                result_source = RES_MEM;
            end
            OP_SW: begin
                mem_write  = 1'b1;
                alu_source = 1'b1;
                imm_type   = IMM_S;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALU_OP_FUNC;
                is_rtype  = 1'b1;
            end
            OP_IALU: begin
                reg_write  = 1'b1;
                alu_source = 1'b1;
                alu_op     = ALU_OP_FUNC;
            end
            OP_BRANCH: begin
                imm_type  = IMM_B;
                alu_op    = ALU_OP_SUB;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                reg_write     = 1'b1;
                result_source = RES_PC4;
                imm_type      = IMM_J;
                is_jal        = 1'b1;
            end
            default: op_illegal = 1'b1;
        endcase
    end

    control_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .func3       (func3),
        .func7_5     (func7[5]),
        .is_rtype    (is_rtype),
        .alu_control (alu_control),
        .illegal     (alu_illegal)
    );

    // Every branch opcode is treated as BEQ
    assign pc_src        = is_branch ? zero : is_jal;
    assign illegal_instr = op_illegal | alu_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | illegal_instr;
        end
    end

endmodule

// File: tb/tb_control.sv
// Directed bench for the RV32I control block: decode vectors per instruction
// class and the sticky illegal-instruction flag.
module tb_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] op_code;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       reg_write;
    logic       mem_write;
    logic       alu_source;
    logic [1:0] result_source;
    logic [2:0] imm_type;
    logic [2:0] alu_control;
    logic       pc_src;
    logic       illegal_instr;
    logic       illegal_seen;

    // {reg_write, mem_write, alu_source, result_source, imm_type, alu_control, pc_src, illegal_instr}
    logic [14:0] dec_act;

    int vec_cnt = 0;
    int err_cnt = 0;

    control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_code       (op_code),
        .func3         (func3),
        .func7         (func7),
        .zero          (zero),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .alu_source    (alu_source),
        .result_source (result_source),
        .imm_type      (imm_type),
        .alu_control   (alu_control),
        .pc_src        (pc_src),
        .illegal_instr (illegal_instr),
        .illegal_seen  (illegal_seen)
    );

    assign dec_act = {reg_write, mem_write, alu_source, result_source, imm_type,
                      alu_control, pc_src, illegal_instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z);
        @(negedge clk);
        op_code = op;
        func3   = f3;
        func7   = f7;
        zero    = z;
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        op_code = 7'b0000011;
        func3   = 3'b111;
        func7   = 7'b0100000;
        zero    = 1'b0;
        #3;
        vec_cnt++;
        if (illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_seen: got %b want 0", illegal_seen);
        end
        vec_cnt++;
        if (dec_act !== 15'b1_0_1_01_000_000_0_0) begin
            err_cnt++;
            $display("FAIL decode_in_reset: got %b want %b", dec_act, 15'b1_0_1_01_000_000_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw_sw;
        drive(7'b0000011, 3'b010, 7'b0000000, 1'b1);
        vec_cnt++;
        if (dec_act !== 15'b1_0_1_01_000_000_0_0) begin
            err_cnt++;
            $display("FAIL lw: got %b want %b", dec_act, 15'b1_0_1_01_000_000_0_0);
        end
        drive(7'b0100011, 3'b101, 7'b0100000, 1'b1);
        vec_cnt++;
        if (dec_act !== 15'b0_1_1_00_001_000_0_0) begin
            err_cnt++;
            $display("FAIL sw: got %b want %b", dec_act, 15'b0_1_1_00_001_000_0_0);
        end
    endtask

    task automatic test_rtype;
        logic [2:0]  f3_tab [8]  = '{3'b000, 3'b111, 3'b110, 3'b000, 3'b010, 3'b100, 3'b001, 3'b101};
        logic [6:0]  f7_tab [8]  = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
        logic [2:0]  alu_tab [8] = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b111};
        logic [14:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(7'b0110011, f3_tab[i], f7_tab[i], 1'b1);
            exp = {1'b1, 1'b0, 1'b0, 2'b00, 3'b000, alu_tab[i], 1'b0, 1'b0};
            vec_cnt++;
            if (dec_act !== exp) begin
                err_cnt++;
                $display("FAIL rtype_f3_%b_f7_%b: got %b want %b", f3_tab[i], f7_tab[i], dec_act, exp);
            end
        end
    endtask

    task automatic test_beq;
        drive(7'b1100011, 3'b110, 7'b0100000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b0_0_0_00_010_001_0_0) begin
            err_cnt++;
            $display("FAIL beq_not_taken: got %b want %b", dec_act, 15'b0_0_0_00_010_001_0_0);
        end
        drive(7'b1100011, 3'b110, 7'b0100000, 1'b1);
        vec_cnt++;
        if (dec_act !== 15'b0_0_0_00_010_001_1_0) begin
            err_cnt++;
            $display("FAIL beq_taken: got %b want %b", dec_act, 15'b0_0_0_00_010_001_1_0);
        end
    endtask

    task automatic test_jal_addi;
        drive(7'b1101111, 3'b011, 7'b0100000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b1_0_0_10_011_000_1_0) begin
            err_cnt++;
            $display("FAIL jal: got %b want %b", dec_act, 15'b1_0_0_10_011_000_1_0);
        end
        drive(7'b0010011, 3'b000, 7'b0100000, 1'b1);
        vec_cnt++;
        if (dec_act !== 15'b1_0_1_00_000_000_0_0) begin
            err_cnt++;
            $display("FAIL addi_no_sub: got %b want %b", dec_act, 15'b1_0_1_00_000_000_0_0);
        end
        drive(7'b0010011, 3'b110, 7'b0000000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b1_0_1_00_000_011_0_0) begin
            err_cnt++;
            $display("FAIL ori: got %b want %b", dec_act, 15'b1_0_1_00_000_011_0_0);
        end
        vec_cnt++;
        if (illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL seen_after_legal: got %b want 0", illegal_seen);
        end
    endtask

    task automatic test_illegal_funcs;
        drive(7'b0110011, 3'b011, 7'b0000000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b1_0_0_00_000_000_0_1) begin
            err_cnt++;
            $display("FAIL rtype_f3_011: got %b want %b", dec_act, 15'b1_0_0_00_000_000_0_1);
        end
        drive(7'b0110011, 3'b101, 7'b0100000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b1_0_0_00_000_111_0_1) begin
            err_cnt++;
            $display("FAIL sra: got %b want %b", dec_act, 15'b1_0_0_00_000_111_0_1);
        end
        drive(7'b0010011, 3'b101, 7'b0100000, 1'b0);
        vec_cnt++;
        if (dec_act !== 15'b1_0_1_00_000_111_0_1) begin
            err_cnt++;
            $display("FAIL srai: got %b want %b", dec_act, 15'b1_0_1_00_000_111_0_1);
        end
        drive(7'b0110111, 3'b000, 7'b0000000, 1'b1);
        vec_cnt++;
        if (dec_act !== 15'b0_0_0_00_000_000_0_1) begin
            err_cnt++;
            $display("FAIL lui_unsupported: got %b want %b", dec_act, 15'b0_0_0_00_000_000_0_1);
        end
    endtask

    task automatic test_status;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL seen_async_clear: got %b want 0", illegal_seen);
        end
        op_code = 7'b0000011;
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b0000000, 3'b000, 7'b0000000, 1'b0);
        vec_cnt++;
        if (illegal_instr !== 1'b1 || illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL illegal_before_edge: got instr %b seen %b want 1 0", illegal_instr, illegal_seen);
        end
        drive(7'b0000011, 3'b000, 7'b0000000, 1'b0);
        vec_cnt++;
        if (illegal_instr !== 1'b0 || illegal_seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL seen_set: got instr %b seen %b want 0 1", illegal_instr, illegal_seen);
        end
        for (int i = 0; i < 3; i++) begin
            drive(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        end
        vec_cnt++;
        if (illegal_seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL seen_sticky: got %b want 1", illegal_seen);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL seen_midrun_clear: got %b want 0", illegal_seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b0000011, 3'b000, 7'b0000000, 1'b0);
        vec_cnt++;
        if (illegal_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL seen_after_rearm: got %b want 0", illegal_seen);
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_rtype();
        test_beq();
        test_jal_addi();
        test_illegal_funcs();
        test_status();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
